// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: hands the shared address/memory bus between the CPU control
// pipeline (default owner) and one external DMA requester.
//
// Ports:
//   clk              system clock, all state updates on the rising edge
//   reset            synchronous, active-high reset
//   cpu_bus_request  stage-2 control bit, high = CPU locks the bus this cycle
//   dma_req          DMA bus request (level, held until done)
//   dma_done         DMA finished (one-cycle pulse, only meaningful while granted)
//   dma_grant        DMA may drive the address/memory bus
//   cpu_stall        freeze the pipeline
//   addr_drive_cpu   CPU address sources may drive the address bus
//   addr_drive_dma   DMA address source may drive the address bus
//   dma_timeout      one-cycle pulse when a grant was cut off by MAX_BURST
//   burst_count      cycles elapsed in the current DMA grant (0 outside DMA)
//   arb_state        current state encoding (debug)
//
// All outputs decode registered state only; there is no combinational path
// from any input to any output.

module mem_bus_arbiter #(
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned CPU_MIN   = 4,
   parameter int unsigned CW        = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_bus_request,
   input  logic          dma_req,
   input  logic          dma_done,
   output logic          dma_grant,
   output logic          cpu_stall,
   output logic          addr_drive_cpu,
   output logic          addr_drive_dma,
   output logic          dma_timeout,
   output logic [CW-1:0] burst_count,
   output logic [1:0]    arb_state
);

   typedef enum logic [1:0] {
      StCpu     = 2'd0,
      StHandoff = 2'd1,
      StDma     = 2'd2,
      StReturn  = 2'd3
   } arb_state_e;

   localparam logic [CW-1:0] BurstLast = CW'(MAX_BURST - 1);
   localparam logic [CW-1:0] CpuMinVal = CW'(CPU_MIN);

   arb_state_e    state_q, state_d;
   logic [CW-1:0] burst_q, burst_d;
   logic [CW-1:0] holdoff_q, holdoff_d;
   logic          timeout_q, timeout_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StCpu;
         burst_q   <= '0;
         holdoff_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         burst_q   <= burst_d;
         holdoff_q <= holdoff_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      burst_d   = burst_q;
      holdoff_d = holdoff_q;
      timeout_d = 1'b0;
      unique case (state_q)
         StCpu: begin
            burst_d = '0;
            if (holdoff_q != '0) holdoff_d = holdoff_q - 1'b1;
            // DMA may only enter when the CPU control word is not locking the bus
            // and the post-release CPU window has fully elapsed.
            if (dma_req && !cpu_bus_request && (holdoff_q == '0)) state_d = StHandoff;
         end
         StHandoff: begin
            burst_d = '0;
            state_d = dma_req ? StDma : StReturn;
         end
         StDma: begin
            if (dma_done || !dma_req || (burst_q == BurstLast)) begin
               state_d   = StReturn;
               burst_d   = '0;
               // Only a forced release counts as a timeout.
               timeout_d = !dma_done && dma_req;
            end else begin
               burst_d = burst_q + 1'b1;
            end
         end
         StReturn: begin
            burst_d   = '0;
            holdoff_d = CpuMinVal;
            state_d   = StCpu;
         end
         default: state_d = StCpu;
      endcase
   end

   always_comb begin
      dma_grant      = (state_q == StDma);
      addr_drive_dma = (state_q == StDma);
      addr_drive_cpu = (state_q == StCpu);
      cpu_stall      = (state_q != StCpu);
      dma_timeout    = timeout_q;
      burst_count    = burst_q;
      arb_state      = state_q;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Arbitrates the shared address/memory bus between the CPU control pipeline and one external DMA-style requester. The CPU owns the bus by default. DMA gets the bus only at a point where the CPU control word is not locking the bus (bus_request low). While DMA owns the bus, the arbiter stalls the pipeline, bounds DMA tenure with a burst limit, and guarantees the CPU a minimum ownership window afterwards. It sits between the stage-2 control outputs and the address-bus drivers.

Parameters:
MAX_BURST, 16, maximum consecutive DMA-owned cycles before forced release (>=1)
CPU_MIN, 4, minimum CPU-owned cycles after a DMA release before DMA may be re-granted (>=0)
CW, 5, width of burst/holdoff counters; must hold max(MAX_BURST, CPU_MIN)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
cpu_bus_request  in  1  stage-2 bus_request control bit; high = CPU locks bus this cycle
dma_req  in  1  DMA requests bus; level, held until done
dma_done  in  1  DMA finished; one-cycle pulse, valid only while granted
dma_grant  out  1  DMA may drive address/memory bus this cycle
cpu_stall  out  1  freeze pipeline (stage clocks/loads held)
addr_drive_cpu  out  1  CPU address sources may drive address bus
addr_drive_dma  out  1  DMA address source may drive address bus
dma_timeout  out  1  one-cycle pulse when a grant ends by MAX_BURST
burst_count  out  CW  cycles elapsed in current DMA grant (0 outside DMA)
arb_state  out  2  current state encoding (debug)

Behaviour:
- States: CPU=0, HANDOFF=1, DMA=2, RETURN=3. Moore: all outputs decode registered state/counters, no comb path from inputs to outputs.
- Reset values: state CPU, dma_grant 0, cpu_stall 0, addr_drive_cpu 1, addr_drive_dma 0, dma_timeout 0, burst_count 0, holdoff 0. Reset overrides everything, including mid-DMA: bus returns to CPU on the next cycle with no RETURN cycle.
- CPU: addr_drive_cpu=1, others 0. holdoff decrements toward 0, saturating.
  -> HANDOFF when dma_req=1 and cpu_bus_request=0 and holdoff=0. Otherwise stay.
- HANDOFF: 1-cycle turnaround. Both drivers 0, cpu_stall=1, grant 0.
  -> DMA if dma_req=1; else RETURN (request withdrawn).
- DMA: dma_grant=1, addr_drive_dma=1, cpu_stall=1. burst_count starts at 0 on the first DMA cycle and increments each DMA cycle.
  -> RETURN when dma_done=1, or dma_req=0, or burst_count=MAX_BURST-1.
  - Timeout exit: dma_timeout pulses in the first RETURN cycle, only if dma_done=0 and dma_req=1 at the exit edge.
- RETURN: 1-cycle turnaround. Both drivers 0, cpu_stall=1, grant 0, burst_count cleared. Loads holdoff=CPU_MIN. -> CPU unconditionally.
- Latency: with CPU idle and holdoff=0, dma_req rising at edge N gives HANDOFF at N+1 and dma_grant at N+2.
- Stall rule: cpu_stall is high in every non-CPU state. Pipeline controls sampled during stall are ignored.
- Invariant: addr_drive_cpu and addr_drive_dma are never both 1. Neither is 1 in HANDOFF or RETURN.
- dma_done outside DMA is ignored.
- dma_req held continuously: alternates max MAX_BURST DMA cycles, then RETURN, then >=CPU_MIN CPU cycles. The CPU can never starve.
- CPU_MIN=0: re-grant is possible on the first CPU cycle after RETURN.

Test Plan:
- Reset/default: assert reset 2 cycles -> state 0, addr_drive_cpu=1, cpu_stall=0, grant=0. Then dma_done pulses -> no change.
- Basic grant: dma_req=1 at cycle 0, cpu_bus_request=0 -> HANDOFF cycle 1, grant cycles 2-4. dma_done at cycle 4 -> RETURN cycle 5, CPU cycle 6, no dma_timeout.
- Bus lock: cpu_bus_request=1 for cycles 0-5 with dma_req=1 -> remains CPU, no stall. Drop lock at 6 -> HANDOFF at 7.
- Burst limit: MAX_BURST=16, CPU_MIN=4, dma_req held -> exactly 16 grant cycles (burst_count 0..15), dma_timeout one pulse. Next HANDOFF no earlier than 4 CPU cycles after RETURN; pattern repeats.
- Withdraw: dma_req drops during HANDOFF -> RETURN, never grant. Drops mid-DMA -> RETURN next cycle, no timeout.
- Reset mid-DMA: reset at grant cycle 3 -> next cycle CPU state, addr_drive_dma=0, burst_count=0, holdoff=0. No drive overlap in any cycle, checked across all tests.
